// File: rtl/disp_pkg.sv
// Shared constants, frame record type and leading-digit helper for the display scan multiplexer.
package disp_pkg;
  localparam logic [3:0] AN_OFF      = 4'b1111;
  localparam int         NUM_DIGITS  = 4;
  localparam int         CLK_DIV_DEF = 50000;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
  } frame_t;

  // Index of the most significant nonzero nibble; 0 when the whole word is zero.
  function automatic logic [1:0] msd_idx(input logic [15:0] d);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (d[4*i +: 4] != 4'h0) r = 2'(i);
    return r;
  endfunction
endpackage

// File: rtl/disp_prescaler.sv
// Free-running 0..CLK_DIV-1 counter; tick is high while the count sits at its last value.
module disp_prescaler
  import disp_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int             CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_cnt <= '0;
    else if (r_cnt == LAST)  r_cnt <= '0;
    else                     r_cnt <= r_cnt + 1'b1;
  end

  assign tick = (r_cnt == LAST);
endmodule

// File: rtl/disp_scan_mux.sv
// Four-digit multiplexed 7-segment scanner with frame-synchronous shadow loading.
// Optional macro DISP_LZ_BLANK_EN suppresses leading-zero digits.
module disp_scan_mux
  import disp_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        blank,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame_start,
  output logic        pending
);
  logic       w_tick, w_wrap, w_show, w_dpbit;
  logic [3:0] w_nib, w_an_on;
  logic [1:0] r_idx;
  frame_t     r_shadow, r_disp;
  logic       r_pending;
  logic [1:0] r_wrap_pipe;
  logic [3:0] r_an, r_digit;
  logic       r_dp;

  disp_prescaler #(.CLK_DIV(CLK_DIV)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  assign w_wrap = w_tick && (r_idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_idx <= '0;
    else if (w_tick) r_idx <= r_idx + 2'd1;
  end

  // A load landing on the wrap tick bypasses the shadow so it shows this frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow  <= '0;
      r_disp    <= '0;
      r_pending <= 1'b0;
    end else if (w_wrap) begin
      r_pending <= 1'b0;
      if (load) begin
        r_disp   <= '{data: data_in, dp: dp_in};
        r_shadow <= '{data: data_in, dp: dp_in};
      end else begin
        r_disp   <= r_shadow;
      end
    end else if (load) begin
      r_shadow  <= '{data: data_in, dp: dp_in};
      r_pending <= 1'b1;
    end
  end

  assign w_nib   = r_disp.data[{r_idx, 2'b00} +: 4];
  assign w_dpbit = r_disp.dp[r_idx];

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_an
    assign w_an_on[g] = (r_idx != 2'(g));
  end

`ifdef DISP_LZ_BLANK_EN
  assign w_show = (r_idx <= msd_idx(r_disp.data)) || w_dpbit;
`else
  assign w_show = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an        <= AN_OFF;
      r_digit     <= '0;
      r_dp        <= 1'b1;
      r_wrap_pipe <= '0;
    end else begin
      r_wrap_pipe <= {r_wrap_pipe[0], w_wrap};
      r_digit     <= w_nib;
      if (blank || !w_show) begin
        r_an <= AN_OFF;
        r_dp <= 1'b1;
      end else begin
        r_an <= w_an_on;
        r_dp <= ~w_dpbit;
      end
    end
  end

  assign an          = r_an;
  assign digit       = r_digit;
  assign dp          = r_dp;
  assign frame_start = r_wrap_pipe[1];
  assign pending     = r_pending;
endmodule

// File: tb/tb_disp_scan_mux.sv
// Bench for disp_scan_mux at CLK_DIV=4: directed frames, then random loads/blanking against a timeline model.
module tb_disp_scan_mux;
  localparam int CD = 4;
  localparam int FR = 4 * CD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        blank = 1'b0;
  logic [3:0]  digit, an;
  logic        dp, frame_start, pending;

  int          n, n_pass, n_total;
  logic [15:0] m_sh, m_disp;
  logic [3:0]  m_shdp, m_dispdp;
  int          m_last_ld;

  disp_scan_mux #(.CLK_DIV(CD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .dp_in       (dp_in),
    .load        (load),
    .blank       (blank),
    .digit       (digit),
    .an          (an),
    .dp          (dp),
    .frame_start (frame_start),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h at edge %0d", tag, obs, exp, n);
  endtask

  task automatic chk_reset();
    chk("rst_an",      16'(an),          16'hF);
    chk("rst_digit",   16'(digit),       16'h0);
    chk("rst_dp",      16'(dp),          16'h1);
    chk("rst_fs",      16'(frame_start), 16'h0);
    chk("rst_pending", 16'(pending),     16'h0);
  endtask

  task automatic model_reset();
    n = 0; m_sh = '0; m_disp = '0; m_shdp = '0; m_dispdp = '0; m_last_ld = -1;
  endtask

  // Edge n+1 shows the slot held after edge n: slot s spans edges s*CD+1 .. (s+1)*CD of each frame.
  // Frames start at edges that are multiples of FR; the shown word is the latest load up to that edge.
  task automatic cyc();
    int         slot;
    logic       show, e_off, e_dp, e_fs, e_pend;
    logic [3:0] e_an, e_dig;
    slot = (n / CD) % 4;
    show = 1'b1;
`ifdef DISP_LZ_BLANK_EN
    begin
      int msd;
      msd = 0;
      for (int i = 0; i < 4; i++) if (m_disp[4*i +: 4] != 4'h0) msd = i;
      show = (slot <= msd) || m_dispdp[slot];
    end
`endif
    e_off = blank || !show;
    e_an  = e_off ? 4'hF : ~(4'b0001 << slot);
    e_dig = m_disp[4*slot +: 4];
    e_dp  = e_off ? 1'b1 : ~m_dispdp[slot];
    if (load) begin
      m_sh = data_in; m_shdp = dp_in; m_last_ld = n + 1;
    end
    if ((n + 1) % FR == 0) begin
      m_disp = m_sh; m_dispdp = m_shdp;
    end
    e_pend = m_last_ld > FR * ((n + 1) / FR);
    e_fs   = (n >= FR) && (n % FR == 0);
    @(posedge clk);
    #1;
    n++;
    load = 1'b0;
    chk("an",          16'(an),          16'(e_an));
    chk("digit",       16'(digit),       16'(e_dig));
    chk("dp",          16'(dp),          16'(e_dp));
    chk("frame_start", 16'(frame_start), 16'(e_fs));
    chk("pending",     16'(pending),     16'(e_pend));
  endtask

  task automatic run_to(input int t);
    while (n < t) cyc();
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    model_reset();
    // load asserted throughout reset must be ignored
    load = 1'b1; data_in = 16'hFFFF; dp_in = 4'hF;
    repeat (3) begin
      @(posedge clk); #1;
      chk_reset();
    end
    load = 1'b0;
    rst_n = 1'b1;

    run_to(37);
    data_in = 16'h1234; dp_in = 4'b0000; load = 1'b1;
    cyc();
    run_to(63);
    data_in = 16'hABCD; dp_in = 4'b0101; load = 1'b1;
    cyc();
    run_to(70);
    data_in = 16'h1111; dp_in = 4'b1111; load = 1'b1;
    cyc();
    run_to(75);
    data_in = 16'h2222; dp_in = 4'b0010; load = 1'b1;
    cyc();
    run_to(96);
    blank = 1'b1;
    run_to(112);
    blank = 1'b0;
    run_to(120);
    data_in = 16'h0050; dp_in = 4'b0000; load = 1'b1;
    cyc();
    run_to(160);

    // asynchronous reset mid-run with a load present at the edge inside reset
    rst_n = 1'b0; load = 1'b1; data_in = 16'h9999; dp_in = 4'hF;
    #2;
    chk_reset();
    @(posedge clk); #1;
    chk_reset();
    rst_n = 1'b1; load = 1'b0;
    model_reset();
    run_to(20);

    repeat (320) begin
      if ($urandom_range(7) == 0) begin
        load    = 1'b1;
        data_in = 16'($urandom) >> (4 * $urandom_range(3));
        dp_in   = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
      end
      blank = ($urandom_range(15) == 0);
      cyc();
    end
    blank = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
